// File: rtl/booth_pkg.sv
// Shared types and default sizing for the Booth multiplier core, its sequencer and bench.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } seq_state_e;

  localparam int unsigned WORD_LENGTH_DEF = 16;
  localparam int unsigned TIMEOUT_DEF     = 40;

endpackage

// File: rtl/booth_watchdog.sv
// Cycle counter with synchronous clear and enable; flags expiry at TIMEOUT_CYCLES-1.
module booth_watchdog
  import booth_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/booth_mult_sequencer.sv
// Handshaked launch/capture sequencer for the sequential Booth multiplier core.
// Optional overflow detection enabled by defining BOOTH_OVF_DETECT_EN.
module booth_mult_sequencer
  import booth_pkg::*;
#(
  parameter int unsigned WORD_LENGTH    = WORD_LENGTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_LENGTH-1:0]   op_multiplier,
  input  logic [WORD_LENGTH-1:0]   op_multiplicand,
  output logic                     mult_start,
  output logic [WORD_LENGTH-1:0]   mult_multiplier,
  output logic [WORD_LENGTH-1:0]   mult_multiplicand,
  input  logic                     mult_ready,
  input  logic [2*WORD_LENGTH-1:0] mult_product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_LENGTH-1:0]   Result,
  output logic                     sign,
  output logic                     error,
  output logic                     overflow
);

  seq_state_e state_q, state_d;
  logic [WORD_LENGTH-1:0] mplier_q, mplier_d;
  logic [WORD_LENGTH-1:0] mcand_q, mcand_d;
  logic [WORD_LENGTH-1:0] result_q, result_d;
  logic                   sign_q, sign_d;
  logic                   error_q, error_d;
  logic                   wd_expired;

  booth_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (reset),
    .clr    (state_q == START),
    .en     (state_q == WAIT),
    .expired(wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    sign_d   = sign_q;
    error_d  = error_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mplier_d = op_multiplier;
          mcand_d  = op_multiplicand;
          state_d  = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // A completing core takes priority over a watchdog expiring in the same cycle.
        if (mult_ready) begin
          result_d = mult_product[WORD_LENGTH-1:0];
          sign_d   = mult_product[2*WORD_LENGTH-1];
          error_d  = 1'b0;
          state_d  = DONE;
        end else if (wd_expired) begin
          result_d = '0;
          sign_d   = 1'b0;
          error_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mplier_q <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      error_q  <= error_d;
    end
  end

`ifdef BOOTH_OVF_DETECT_EN
  logic [WORD_LENGTH:0] prod_hi;
  logic                 ovf_q, ovf_d;

  // Product fits WORD_LENGTH signed bits only if the top WL+1 bits are all equal.
  assign prod_hi = mult_product[2*WORD_LENGTH-1:WORD_LENGTH-1];

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == WAIT) begin
      if (mult_ready) begin
        ovf_d = ~((&prod_hi) | ~(|prod_hi));
      end else if (wd_expired) begin
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign in_ready          = (state_q == IDLE);
  assign mult_start        = (state_q == START);
  assign out_valid         = (state_q == DONE);
  assign mult_multiplier   = mplier_q;
  assign mult_multiplicand = mcand_q;
  assign Result            = result_q;
  assign sign              = sign_q;
  assign error             = error_q;

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Directed self-checking bench for booth_mult_sequencer with a behavioural core model.
module tb_booth_mult_sequencer;
  import booth_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_multiplier;
  logic [15:0] op_multiplicand;
  logic        mult_start;
  logic [15:0] mult_multiplier;
  logic [15:0] mult_multiplicand;
  logic        mult_ready;
  logic [31:0] mult_product;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Result;
  logic        sign;
  logic        error;
  logic        overflow;

  int checks;
  int fails;
  int start_cnt;
  bit core_hang;
  int core_lat;

`ifdef BOOTH_OVF_DETECT_EN
  localparam logic OVF_EXP_BIG = 1'b1;
`else
  localparam logic OVF_EXP_BIG = 1'b0;
`endif

  booth_mult_sequencer #(
    .WORD_LENGTH   (WORD_LENGTH_DEF),
    .TIMEOUT_CYCLES(TIMEOUT_DEF)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .op_multiplier    (op_multiplier),
    .op_multiplicand  (op_multiplicand),
    .mult_start       (mult_start),
    .mult_multiplier  (mult_multiplier),
    .mult_multiplicand(mult_multiplicand),
    .mult_ready       (mult_ready),
    .mult_product     (mult_product),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .Result           (Result),
    .sign             (sign),
    .error            (error),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mult_start === 1'b1) start_cnt++;
  end

  // Core model: raises mult_ready core_lat cycles after seeing the start pulse.
  initial begin
    mult_ready   = 1'b0;
    mult_product = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!core_hang && mult_start === 1'b1) begin
        repeat (core_lat) begin
          @(posedge clk);
          #1;
        end
        mult_product = $signed(mult_multiplier) * $signed(mult_multiplicand);
        mult_ready   = 1'b1;
        @(posedge clk);
        #1;
        mult_ready   = 1'b0;
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid        = 1'b1;
    op_multiplier   = a;
    op_multiplicand = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (mult_start !== 1'b0) begin fails++; $display("FAIL reset_mult_start got %b exp 0", mult_start); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (Result !== 16'h0000) begin fails++; $display("FAIL reset_result got %h exp 0000", Result); end
    checks++; if ({sign, error, overflow} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {sign, error, overflow}); end
    checks++; if (mult_multiplier !== 16'h0000 || mult_multiplicand !== 16'h0000) begin
      fails++; $display("FAIL reset_operands got %h/%h exp 0000/0000", mult_multiplier, mult_multiplicand);
    end
  endtask

  task automatic test_basic;
    int n;
    out_ready = 1'b1;
    start_cnt = 0;
    send(16'h0003, 16'hFFFC);
    checks++; if (mult_multiplier !== 16'h0003 || mult_multiplicand !== 16'hFFFC) begin
      fails++; $display("FAIL basic_operands got %h/%h exp 0003/fffc", mult_multiplier, mult_multiplicand);
    end
    wait_valid(n);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid got %b exp 1", out_valid); end
    checks++; if (Result !== 16'hFFF4) begin fails++; $display("FAIL basic_result got %h exp fff4", Result); end
    checks++; if (sign !== 1'b1) begin fails++; $display("FAIL basic_sign got %b exp 1", sign); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL basic_error got %b exp 0", error); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL basic_overflow got %b exp 0", overflow); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL basic_release got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    checks++; if (start_cnt !== 1) begin fails++; $display("FAIL basic_start_pulses got %0d exp 1", start_cnt); end
  endtask

  task automatic test_overflow;
    int n;
    out_ready = 1'b1;
    send(16'h7FFF, 16'h7FFF);
    wait_valid(n);
    checks++; if (Result !== 16'h0001) begin fails++; $display("FAIL ovf_result got %h exp 0001", Result); end
    checks++; if (sign !== 1'b0) begin fails++; $display("FAIL ovf_sign got %b exp 0", sign); end
    checks++; if (overflow !== OVF_EXP_BIG) begin fails++; $display("FAIL ovf_flag got %b exp %b", overflow, OVF_EXP_BIG); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    core_hang = 1'b1;
    out_ready = 1'b0;
    send(16'h0011, 16'h0022);
    checks++; if (mult_start !== 1'b1) begin fails++; $display("FAIL to_start got %b exp 1", mult_start); end
    wait_valid(n);
    // START cycle, then 40 WAIT cycles, then DONE
    checks++; if (n !== 41) begin fails++; $display("FAIL to_latency got %0d exp 41", n); end
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL to_error got %b exp 1", error); end
    checks++; if (Result !== 16'h0000 || sign !== 1'b0) begin fails++; $display("FAIL to_result got %h/%b exp 0000/0", Result, sign); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL to_overflow got %b exp 0", overflow); end
    core_hang = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL to_in_ready got %b exp 1", in_ready); end
    send(16'h0002, 16'h0003);
    wait_valid(n);
    checks++; if (Result !== 16'h0006 || error !== 1'b0) begin
      fails++; $display("FAIL to_recover got %h err=%b exp 0006 err=0", Result, error);
    end
    @(negedge clk);
  endtask

  task automatic test_back_pressure;
    int n;
    int bad_valid, bad_res, bad_rdy;
    out_ready = 1'b0;
    start_cnt = 0;
    send(16'h0005, 16'hFFFD);
    wait_valid(n);
    bad_valid = 0; bad_res = 0; bad_rdy = 0;
    in_valid = 1'b1;
    op_multiplier = 16'h1111;
    op_multiplicand = 16'h2222;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1) bad_valid++;
      if (Result !== 16'hFFF1 || sign !== 1'b1) bad_res++;
      if (in_ready !== 1'b0) bad_rdy++;
    end
    checks++; if (bad_valid !== 0) begin fails++; $display("FAIL bp_out_valid drops got %0d exp 0", bad_valid); end
    checks++; if (bad_res !== 0) begin fails++; $display("FAIL bp_result_changes got %0d exp 0 (now %h)", bad_res, Result); end
    checks++; if (bad_rdy !== 0) begin fails++; $display("FAIL bp_in_ready_high got %0d exp 0", bad_rdy); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release got %b exp 0", out_valid); end
    checks++; if (start_cnt !== 1) begin fails++; $display("FAIL bp_start_pulses got %0d exp 1", start_cnt); end
  endtask

  task automatic test_reset_mid_wait;
    core_hang = 1'b1;
    out_ready = 1'b0;
    send(16'h1234, 16'h0002);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || mult_start !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL rst_ctrl got in_ready=%b start=%b out_valid=%b exp 1/0/0", in_ready, mult_start, out_valid);
    end
    checks++; if (mult_multiplier !== 16'h0000 || mult_multiplicand !== 16'h0000) begin
      fails++; $display("FAIL rst_operands got %h/%h exp 0000/0000", mult_multiplier, mult_multiplicand);
    end
    checks++; if (Result !== 16'h0000 || {sign, error, overflow} !== 3'b000) begin
      fails++; $display("FAIL rst_outputs got %h/%b exp 0000/000", Result, {sign, error, overflow});
    end
    reset = 1'b1;
    core_hang = 1'b0;
    start_cnt = 0;
    repeat (10) @(negedge clk);
    checks++; if (start_cnt !== 0) begin fails++; $display("FAIL rst_no_restart got %0d exp 0", start_cnt); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_idle got %b exp 1", in_ready); end
  endtask

  task automatic test_ready_vs_timeout;
    int n;
    core_lat = 40;
    out_ready = 1'b0;
    send(16'h0003, 16'h0005);
    wait_valid(n);
    checks++; if (n !== 41) begin fails++; $display("FAIL tie_latency got %0d exp 41", n); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL tie_error got %b exp 0", error); end
    checks++; if (Result !== 16'h000F || sign !== 1'b0) begin fails++; $display("FAIL tie_result got %h/%b exp 000f/0", Result, sign); end
    out_ready = 1'b1;
    @(negedge clk);
    core_lat = 1;
  endtask

  initial begin
    checks = 0;
    fails = 0;
    start_cnt = 0;
    core_hang = 1'b0;
    core_lat = 1;
    reset = 1'b0;
    in_valid = 1'b0;
    op_multiplier = '0;
    op_multiplicand = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b1;
    test_basic;
    test_overflow;
    test_timeout;
    test_back_pressure;
    test_reset_mid_wait;
    test_ready_vs_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
